// File: rtl/tick_scheduler.sv
// tick_scheduler: multi-channel one-shot/periodic timer block driven by a
// shared, run-time programmable mod-div base-tick prescaler.
// Optional build macro TICK_SCHED_SNAPSHOT_EN adds a registered readback
// port (rd_ch -> rd_cnt, rd_periodic) with one cycle of latency.
module tick_scheduler #(
   parameter int PW       = 27,
   parameter int DIV_INIT = 100000000,
   parameter int N_CH     = 4,
   parameter int CW       = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cfg_we,
   input  logic [PW-1:0]           cfg_div,
   input  logic                    req_valid,
   input  logic [$clog2(N_CH)-1:0] req_ch,
   input  logic [CW-1:0]           req_cnt,
   input  logic                    req_periodic,
   output logic                    req_ready,
   input  logic [N_CH-1:0]         cancel,
   output logic [N_CH-1:0]         busy,
   output logic [N_CH-1:0]         fire,
   output logic                    base_tick
`ifdef TICK_SCHED_SNAPSHOT_EN
   ,
   input  logic [$clog2(N_CH)-1:0] rd_ch,
   output logic [CW-1:0]           rd_cnt,
   output logic                    rd_periodic
`endif
);

   localparam int CHW = $clog2(N_CH);
   localparam logic [PW-1:0] DIV_RST = PW'(DIV_INIT);

   logic [PW-1:0]   div_q;
   logic [PW-1:0]   pcnt;
   logic [N_CH-1:0] armed;
   logic [N_CH-1:0] periodic;
   logic [CW-1:0]   cnt    [N_CH];
   logic [CW-1:0]   reload [N_CH];
   logic            accept;
   logic [CW-1:0]   load_cnt;

   // Divisors 0 and 1 both mean "tick every cycle"; otherwise tick on the last count.
   assign base_tick = (div_q <= PW'(1)) | (pcnt == div_q - PW'(1));

   // Prescaler: count 0..div-1; a divisor write restarts the count from zero.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_q <= DIV_RST;
         pcnt  <= '0;
      end else if (cfg_we) begin
         div_q <= cfg_div;
         pcnt  <= '0;
      end else if (base_tick) begin
         pcnt  <= '0;
      end else begin
         pcnt  <= pcnt + PW'(1);
      end
   end

   // Request decode: a channel outside 0..N_CH-1 never matches, so it is never ready.
   // NOTE: the default assignment first keeps this block purely combinational (no latch).
   always_comb begin
      req_ready = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (req_ch == CHW'(i)) req_ready = ~armed[i] & ~cancel[i];
      end
   end

   assign accept   = req_valid & req_ready;
   assign load_cnt = (req_cnt == '0) ? CW'(1) : req_cnt;
   assign busy     = armed;

   // Channel timers: cancel beats expiry beats arm; fire is a registered one-cycle pulse.
   // NOTE: the small count/reload arrays are reset too, so a reset discards every armed timer cleanly.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         armed    <= '0;
         periodic <= '0;
         fire     <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt[i]    <= '0;
            reload[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            fire[i] <= 1'b0;
            if (cancel[i]) begin
               armed[i] <= 1'b0;
               cnt[i]   <= '0;
            end else if (armed[i] && base_tick) begin
               if (cnt[i] == CW'(1)) begin
                  fire[i] <= 1'b1;
                  if (periodic[i]) begin
                     cnt[i] <= reload[i];
                  end else begin
                     armed[i] <= 1'b0;
                     cnt[i]   <= '0;
                  end
               end else begin
                  cnt[i] <= cnt[i] - CW'(1);
               end
            end else if (accept && (req_ch == CHW'(i))) begin
               // Arm-cycle base_tick is deliberately not counted: this branch excludes decrement.
               armed[i]    <= 1'b1;
               cnt[i]      <= load_cnt;
               reload[i]   <= load_cnt;
               periodic[i] <= req_periodic;
            end
         end
      end
   end

`ifdef TICK_SCHED_SNAPSHOT_EN
   // Readback: remaining count and mode of rd_ch, zero for an idle channel.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_cnt      <= '0;
         rd_periodic <= 1'b0;
      end else begin
         rd_cnt      <= '0;
         rd_periodic <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            if ((rd_ch == CHW'(i)) && armed[i]) begin
               rd_cnt      <= cnt[i];
               rd_periodic <= periodic[i];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed bench for tick_scheduler with a cycle-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_tick_scheduler;

   localparam int PW       = 27;
   localparam int DIV_INIT = 4;
   localparam int N_CH     = 5;
   localparam int CW       = 16;
   localparam int CHW      = $clog2(N_CH);

   logic            clk = 1'b0;
   logic            reset_n;
   logic            cfg_we;
   logic [PW-1:0]   cfg_div;
   logic            req_valid;
   logic [CHW-1:0]  req_ch;
   logic [CW-1:0]   req_cnt;
   logic            req_periodic;
   logic            req_ready;
   logic [N_CH-1:0] cancel;
   logic [N_CH-1:0] busy;
   logic [N_CH-1:0] fire;
   logic            base_tick;

   int checks   = 0;
   int failures = 0;

   tick_scheduler #(.PW(PW), .DIV_INIT(DIV_INIT), .N_CH(N_CH), .CW(CW)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_div(cfg_div),
      .req_valid(req_valid), .req_ch(req_ch), .req_cnt(req_cnt),
      .req_periodic(req_periodic), .req_ready(req_ready), .cancel(cancel),
      .busy(busy), .fire(fire), .base_tick(base_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Prescaler expressed as "cycles since last restart" modulo the divisor;
   // each channel as a remaining-tick count with its reload and mode.
   int              m_div;
   int              m_phase;
   bit              m_valid = 1'b0;
   bit              m_arm [N_CH];
   int              m_rem [N_CH];
   int              m_rl  [N_CH];
   bit              m_per [N_CH];
   logic [N_CH-1:0] m_fire;
   logic [N_CH-1:0] m_busy;
   bit              t_tick;
   bit              t_acc;

   function automatic bit exp_tick();
      if (m_div <= 1) return 1'b1;
      return (m_phase % m_div) == (m_div - 1);
   endfunction

   function automatic bit exp_ready();
      int rc;
      rc = int'(req_ch);
      if (rc >= N_CH) return 1'b0;
      return !m_arm[rc] && !cancel[rc];
   endfunction

   // Compare DUT against model mid-cycle, then advance the model to the next edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            for (int c = 0; c < N_CH; c++) m_busy[c] = m_arm[c];
            check("m_base_tick", 32'(base_tick), 32'(exp_tick()));
            check("m_busy",      32'(busy),      32'(m_busy));
            check("m_fire",      32'(fire),      32'(m_fire));
            check("m_req_ready", 32'(req_ready), 32'(exp_ready()));
         end
         if (!reset_n) begin
            m_div   = DIV_INIT;
            m_phase = 0;
            m_fire  = '0;
            for (int c = 0; c < N_CH; c++) begin
               m_arm[c] = 1'b0;
               m_rem[c] = 0;
               m_rl[c]  = 0;
               m_per[c] = 1'b0;
            end
            m_valid = 1'b1;
         end else if (m_valid) begin
            t_tick = exp_tick();
            t_acc  = req_valid && exp_ready();
            for (int c = 0; c < N_CH; c++) begin
               m_fire[c] = 1'b0;
               if (cancel[c]) begin
                  m_arm[c] = 1'b0;
               end else if (m_arm[c] && t_tick) begin
                  if (m_rem[c] == 1) begin
                     m_fire[c] = 1'b1;
                     if (m_per[c]) m_rem[c] = m_rl[c];
                     else m_arm[c] = 1'b0;
                  end else begin
                     m_rem[c] = m_rem[c] - 1;
                  end
               end else if (t_acc && int'(req_ch) == c) begin
                  m_arm[c] = 1'b1;
                  m_rem[c] = (req_cnt == 0) ? 1 : int'(req_cnt);
                  m_rl[c]  = m_rem[c];
                  m_per[c] = req_periodic;
               end
            end
            if (cfg_we) begin
               m_div   = int'(cfg_div);
               m_phase = 0;
            end else begin
               m_phase++;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits up to maxc cycles for fire[ch]; k is the cycle offset, -1 on timeout.
   task automatic wait_fire(input int ch, input int maxc, output int k);
      k = -1;
      for (int i = 0; i < maxc; i++) begin
         if (fire[ch]) begin
            k = i;
            break;
         end
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] p1, p2;
      int k, n, fo, acc_o;
      logic [N_CH-1:0] nb;

      reset_n = 1'b0; cfg_we = 1'b0; cfg_div = '0; req_valid = 1'b0;
      req_ch = '0; req_cnt = '0; req_periodic = 1'b0; cancel = '0;

      // Reset and default divisor of 4: ticks on cycles 3, 7, 11.
      step(); step();
      reset_n = 1'b1;
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_fire",  32'(fire),      32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      p1 = '0;
      for (int i = 0; i < 12; i++) begin
         p1[i] = base_tick;
         step();
      end
      check("tick_pattern", p1, 32'h888);

      // One-shot ch0, 3 ticks, divisor 4.
      req_valid = 1'b1; req_ch = 3'd0; req_cnt = 16'd3; req_periodic = 1'b0;
      step();
      req_valid = 1'b0;
      check("os_busy", 32'(busy[0]), 32'd1);
      wait_fire(0, 40, k);
      check("os_latency", 32'(k), 32'd11);
      check("os_busy_at_fire", 32'(busy[0]), 32'd0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         n += int'(fire[0]);
      end
      check("os_no_refire", 32'(n), 32'd0);

      // Periodic ch1 (2 ticks) and ch2 (4 ticks) at divisor 2.
      cfg_we = 1'b1; cfg_div = 27'd2;
      req_valid = 1'b1; req_ch = 3'd1; req_cnt = 16'd2; req_periodic = 1'b1;
      step();
      p1 = '0; p2 = '0;
      for (int o = 1; o <= 24; o++) begin
         p1[o] = fire[1];
         p2[o] = fire[2];
         if (o == 1) begin
            cfg_we = 1'b0; req_ch = 3'd2; req_cnt = 16'd4;
         end else if (o == 2) begin
            req_valid = 1'b0;
         end
         step();
      end
      check("per_fire1", p1, 32'h00222220);
      check("per_fire2", p2, 32'h00020200);
      cancel = 5'b00110;
      step();
      cancel = '0;
      check("per_cancel", 32'(busy[2:1]), 32'd0);

      // Stall on busy ch0, cancel in its expiry cycle, then pending arm.
      cfg_we = 1'b1; cfg_div = 27'd2;
      req_valid = 1'b1; req_ch = 3'd0; req_cnt = 16'd5; req_periodic = 1'b0;
      step();
      p1 = '0; p2 = '0; acc_o = 0;
      for (int o = 1; o <= 16; o++) begin
         p1[o] = busy[0];
         p2[o] = fire[0];
         if (o == 1) begin
            cfg_we = 1'b0; req_cnt = 16'd1;
         end
         cancel = (o == 10) ? 5'b00001 : 5'b00000;
         #1;
         if (acc_o != 0) req_valid = 1'b0;
         else if (o >= 2 && req_valid && req_ready) acc_o = o;
         step();
      end
      check("stall_busy", p1, 32'h17FE);
      check("stall_fire", p2, 32'h2000);
      check("stall_accept_cycle", 32'(acc_o), 32'd11);

      // Divisor change mid-count: 10 -> 3.
      cfg_we = 1'b1; cfg_div = 27'd10;
      req_valid = 1'b1; req_ch = 3'd3; req_cnt = 16'd2; req_periodic = 1'b0;
      step();
      cfg_we = 1'b0; req_valid = 1'b0;
      fo = 0;
      for (int o = 1; o <= 30; o++) begin
         if (fire[3] && fo == 0) fo = o;
         cfg_we = (o == 5);
         if (o == 5) cfg_div = 27'd3;
         step();
      end
      check("div_change_fire", 32'(fo), 32'd12);
      cfg_we = 1'b1; cfg_div = 27'd0;
      step();
      cfg_we = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         n += int'(base_tick);
         step();
      end
      check("div0_every_cycle", 32'(n), 32'd4);

      // req_cnt = 0 behaves as 1; arm-cycle tick (div 0) is not counted.
      cfg_we = 1'b1; cfg_div = 27'd4;
      req_valid = 1'b1; req_ch = 3'd4; req_cnt = 16'd0; req_periodic = 1'b0;
      step();
      cfg_we = 1'b0; req_valid = 1'b0;
      wait_fire(4, 20, k);
      check("cnt0_fire", 32'(k), 32'd4);

      // Out-of-range channel is never ready and arms nothing.
      req_valid = 1'b1; req_cnt = 16'd3;
      n = 0; nb = '0;
      for (int i = 0; i < 12; i++) begin
         req_ch = (i < 6) ? 3'd5 : 3'd7;
         #1;
         n += int'(req_ready);
         nb |= busy;
         step();
      end
      req_valid = 1'b0; req_ch = 3'd0;
      check("bad_ch_ready", 32'(n), 32'd0);
      check("bad_ch_busy",  32'(nb), 32'd0);

      // Reset the cycle before an expected fire at divisor 3.
      cfg_we = 1'b1; cfg_div = 27'd3;
      req_valid = 1'b1; req_ch = 3'd0; req_cnt = 16'd2; req_periodic = 1'b0;
      step();
      cfg_we = 1'b0; req_valid = 1'b0;
      for (int o = 1; o <= 5; o++) step();
      check("pre_rst_busy", 32'(busy[0]), 32'd1);
      reset_n = 1'b0;
      step();
      check("rst_fire_supp", 32'(fire), 32'd0);
      check("rst_busy_clr",  32'(busy), 32'd0);
      reset_n = 1'b1;
      fo = -1;
      for (int o = 0; o <= 10; o++) begin
         if (base_tick && fo < 0) fo = o;
         step();
      end
      check("rst_div_restore", 32'(fo), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Multi-channel timeout/period scheduler built around one shared mod-M base-tick prescaler.
- Up to N_CH requesters arm one-shot or periodic timers, counted in base ticks.
- The block arbitrates arm, cancel and fire events on shared counting logic, and allows the prescaler divisor to be reprogrammed at run time.
- Sits between control FSMs (debouncers, LED blinkers, display refresh) and the system clock.

Parameters:
- PW, 27, prescaler counter width in bits.
- DIV_INIT, 100000000, prescaler divisor loaded at reset (base_tick period in clk cycles).
- N_CH, 4, number of timer channels (2..8).
- CW, 16, per-channel tick-count width in bits.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- cfg_we  input  1  load cfg_div into the divisor register.
- cfg_div  input  PW  new prescaler divisor.
- req_valid  input  1  arm request.
- req_ch  input  clog2(N_CH)  channel to arm.
- req_cnt  input  CW  number of base ticks until fire.
- req_periodic  input  1  1 = reload and repeat after each fire; 0 = one-shot.
- req_ready  output  1  arm request can be accepted this cycle.
- cancel  input  N_CH  per-channel disarm strobe.
- busy  output  N_CH  channel is armed.
- fire  output  N_CH  one-cycle expiry pulse per channel.
- base_tick  output  1  one-cycle prescaler wrap pulse.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - divisor = DIV_INIT; prescaler count = 0.
  - All channels IDLE with count 0.
  - busy=0, fire=0, base_tick=0, req_ready=1.
- Prescaler:
  - Counts 0..div-1, then wraps to 0.
  - base_tick=1 combinationally while count==div-1.
  - A divisor of 0 or 1 is treated as 1: base_tick is asserted every cycle.
- Divisor change:
  - cfg_we=1 registers cfg_div and clears the prescaler count to 0 on the same edge.
  - The first base_tick with the new divisor occurs div cycles later.
  - Channel counts are not affected.
- Per-channel FSM, IDLE -> ARMED:
  - Accept when req_valid & req_ready.
  - Registers cnt = max(req_cnt, 1), reload = the same value, and the periodic flag.
  - busy is high from the next cycle.
- ARMED:
  - On each base_tick after the arm cycle, cnt decrements.
  - A base_tick in the same cycle as acceptance is not counted.
- Expiry:
  - When cnt==1 and base_tick=1, fire[ch] is registered high for exactly 1 cycle.
  - One-shot: the channel returns to IDLE (busy low in the same cycle fire is high).
  - Periodic: cnt = reload, stays ARMED, busy stays high.
- Fire latency: fire rises 1 clk after the base_tick edge on which the count expires.
- req_ready = ~busy[req_ch] & ~cancel[req_ch].
  - Requests to a busy channel are stalled, never dropped and never overwrite the armed channel.
  - A requester must hold req_valid/req_ch/req_cnt/req_periodic stable until accepted.
- req_ch >= N_CH: req_ready=0, request never accepted.
- Cancel: cancel[ch]=1 forces IDLE next cycle.
  - Priority: cancel > expiry > accept.
  - A channel expiring in the cancel cycle produces no fire.
- Several channels may fire in the same cycle; no serialisation.
- Only one arm per cycle (single request port). Arm of channel A and expiry of channel B in the same cycle are independent.
- cnt arithmetic: unsigned CW bits; req_cnt=0 behaves as 1; maximum is 2^CW-1 ticks.
- Reset mid-operation: all armed channels are discarded, and any in-flight fire is suppressed on the reset edge.

Optional Feature:
- Macro: TICK_SCHED_SNAPSHOT_EN.
- Defined:
  - Adds input rd_ch [clog2(N_CH)] and outputs rd_cnt [CW] and rd_periodic [1].
  - Registered readback: 1-cycle latency, reflecting the remaining cnt and the periodic flag of channel rd_ch.
  - For an IDLE channel, both read back as 0.
- Undefined: ports absent; no readback logic.

Test Plan:
- Reset/div: DIV_INIT=4, release reset_n -> base_tick high on cycles 3, 7, 11 after release; busy=0, fire=0, req_ready=1.
- One-shot: DIV=4, arm ch0 req_cnt=3 one-shot -> fire[0] exactly once, 1 clk after the 3rd subsequent base_tick; busy[0] low from that cycle; no further fire over 40 cycles.
- Periodic, multi-channel: DIV=2, ch1 cnt=2 periodic and ch2 cnt=4 periodic -> fire[1] every 4 cycles, fire[2] every 8 cycles, coincident pulses both asserted in the same cycle.
- Stall/priority: arm ch0 cnt=5, then req ch0 cnt=1 -> req_ready=0 while busy; no overwrite. Cancel ch0 in its expiry cycle -> no fire[0]; the pending request is accepted only the cycle after busy[0] falls.
- Divisor change: DIV=10, ch3 cnt=2 armed; cfg_we cfg_div=3 mid-count -> prescaler restarts; fire[3] after the second base_tick counted at the new rate. cfg_div=0 -> base_tick every cycle.
- Boundary/reset: req_cnt=0 -> fires after 1 base_tick; req_ch=N_CH -> never accepted. Assert reset_n=0 the cycle before expected fire -> no fire, busy cleared, divisor back to DIV_INIT.
